dma_fsm: RTL and testbench
==========================

# dma_fsm

Top-level descriptor sequencer of the DMA: on a CSR start it walks the descriptor table in index order and launches the read and write `dma_streamer` instances for each enabled descriptor. It waits for both streamers to finish before moving on, then reports completion, abort or error status back to the CSRs. It sits between the CSR bank and the two streamers (read, `STREAM_TYPE=0`; write, `STREAM_TYPE=1`).

## Interface
- No parameters. Sizes come from `` `DMA_NUM_DESC `` and the `dma_utils_pkg` types.
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `dma_go_i` in 1: one-cycle start pulse from the CSRs.
- `dma_abort_i` in 1: level abort from the CSRs; the same signal also goes to both streamers.
- `dma_desc_i` in `s_dma_desc_t [`DMA_NUM_DESC-1:0]`: descriptor table. Only `enable` and `num_bytes` are used here.
- `dma_axi_err_i` in 1: one-cycle pulse from the AXI I/F on an RRESP/BRESP of SLVERR or DECERR.
- `dma_stream_rd_o` out `s_dma_str_in_t`: {valid, idx} to the read streamer.
- `dma_stream_wr_o` out `s_dma_str_in_t`: {valid, idx} to the write streamer.
- `dma_stream_rd_i` in `s_dma_str_out_t`: {done} pulse from the read streamer.
- `dma_stream_wr_i` in `s_dma_str_out_t`: {done} pulse from the write streamer.
- `dma_status_o` out `s_dma_status_t`: {busy, done, error, aborted, err_idx}.
- `dma_done_o` out 1: one-cycle completion pulse, for the IRQ.

## Operation
- States (`dma_fsm_st_t`): IDLE, ISSUE, WAIT, NEXT, ABORT, DONE. Reset state is IDLE.
- A descriptor is **eligible** when `enable==1 && num_bytes!=0`.
- `pick(start)` returns the lowest eligible index ≥ start, plus a found flag.
- **IDLE**
  - On `go` with `pick(0)` found: latch `cur_idx_ff`, clear status, set busy, go to ISSUE.
  - On `go` with nothing eligible: clear status and go to DONE.
  - All other inputs are ignored, including `abort`.
- **ISSUE** (exactly 1 cycle)
  - Drive `rd.valid = wr.valid = 1` with `idx = cur_idx_ff`.
  - Clear `rd_seen_ff` and `wr_seen_ff`, then go to WAIT.
- **WAIT**
  - Each `done` pulse sets its `*_seen_ff`.
  - When both flags are set, counting a pulse arriving this cycle, go to NEXT.
- **NEXT**
  - If `error_ff` is set: go to DONE.
  - Else if `pick(cur_idx_ff+1)` is found: latch the index and go to ISSUE.
  - Else: go to DONE.
  - If `cur_idx_ff==`DMA_NUM_DESC-1`, the search does not wrap; go to DONE.
- **Abort**
  - In ISSUE or WAIT: set `aborted`, go to ABORT.
  - In ABORT, keep collecting `done` pulses. Once both are seen, go to DONE. The streamers may hold RUN until an outstanding beat is accepted, so this wait is unbounded.
  - In NEXT: set `aborted` and go straight to DONE.
  - Abort takes priority over `go`, error and normal transitions.
- **Error**
  - An error pulse in ISSUE, WAIT or ABORT sets sticky `error` and records `err_idx = cur_idx_ff`. Only the first error is recorded.
  - The current descriptor still runs to both `done` pulses; no new descriptor is issued.
- **DONE** (1 cycle)
  - Pulse `dma_done_o`, set sticky `status.done`, clear busy, go to IDLE.
- Sticky `done`, `error`, `aborted` and `err_idx` hold until the next accepted `go`.

## Timing
- Reset values: all outputs 0, including the valids, `dma_done_o` and every status field.
- Launch latency: `go` at cycle N → stream valids high at N+1, for one cycle only. The streamers sample `idx` in that same cycle.
- `idx` on both stream ports holds `cur_idx_ff` at all times outside IDLE. It only changes in NEXT.
- Earliest next launch after the last `done` pulse (at cycle M): valids at M+2 (WAIT→NEXT→ISSUE).
- The two `done` pulses may arrive in any order, in the same cycle, or in the ISSUE+1 cycle. None may be lost.
- `busy` is high from N+1 until the DONE cycle inclusive.
- Reset asserted mid-operation returns to IDLE with all outputs 0 on the next edge. No done pulse is generated.

## Structure
- The following go in `dma_utils_pkg`:
  - `dma_fsm_st_t`;
  - `s_dma_status_t`;
  - the `enable` field of `s_dma_desc_t`;
  - `desc_idx_t` (`$clog2(`DMA_NUM_DESC)` bits, used for `idx` and `err_idx`).
- `pick` is a combinational priority encoder in sub-module `dma_desc_sel`, instantiated twice (start = 0, start = cur+1).
- The FSM, seen flags, index register and status register all live in `dma_fsm`.

## Test plan
- **Two descriptors:** desc 0 and 2 eligible, desc 1 disabled; `go` → valids with idx 0, then idx 2. `dma_done_o` pulses once after both pairs of `done`. Status is {done=1, error=0, aborted=0}.
- **Done order:** rd done 5 cycles before wr done; also rd and wr done in the same cycle; also both in the ISSUE+1 cycle → each case advances exactly once and launches the next index at last done + 2.
- **Nothing eligible:** all descriptors have `num_bytes=0`; `go` → no stream valid, `dma_done_o` at N+2.
- **Abort:** `abort` raised in WAIT while the write done is delayed 10 cycles → stays in ABORT until the write done arrives. Then `dma_done_o` pulses and `aborted=1`; the remaining descriptors are never issued.
- **Error:** error pulse during desc 1 of 3 → desc 1 completes, desc 2 is not launched. Status shows `error=1`, `err_idx=1`. A second error pulse does not change `err_idx`.
- **Go while busy, then reset:** `go` while busy → ignored, no relaunch. Then reset mid-WAIT → IDLE, all outputs 0 next cycle. A fresh `go` afterwards clears the sticky status.

Source files
------------

// File: rtl/dma_utils_pkg.sv
// Shared DMA types: descriptor layout, streamer handshakes, status word and
// the descriptor-sequencer state encoding.
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 4
`endif

package dma_utils_pkg;
  localparam int NUM_DESC     = `DMA_NUM_DESC;
  localparam int DESC_IDX_W   = $clog2(NUM_DESC);
  // One extra bit so that "last index + 1" is representable and never wraps.
  localparam int DESC_START_W = DESC_IDX_W + 1;

  typedef logic [DESC_IDX_W-1:0]   desc_idx_t;
  typedef logic [DESC_START_W-1:0] desc_start_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    ABORT,
    DONE
  } dma_fsm_st_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] num_bytes;
    logic        enable;
  } s_dma_desc_t;

  typedef struct packed {
    logic      valid;
    desc_idx_t idx;
  } s_dma_str_in_t;

  typedef struct packed {
    logic done;
  } s_dma_str_out_t;

  typedef struct packed {
    logic      busy;
    logic      done;
    logic      error;
    logic      aborted;
    desc_idx_t err_idx;
  } s_dma_status_t;

  function automatic logic desc_eligible(input s_dma_desc_t d);
    return d.enable && (d.num_bytes != '0);
  endfunction
endpackage

// File: rtl/dma_desc_sel.sv
// Priority encoder: lowest eligible descriptor index at or above start.
module dma_desc_sel
  import dma_utils_pkg::*;
(
  input  logic [NUM_DESC-1:0] eligible,
  input  desc_start_t         start,
  output logic                found,
  output desc_idx_t           idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = NUM_DESC - 1; i >= 0; i--) begin
      if (eligible[i] && (desc_start_t'(i) >= start)) begin
        found = 1'b1;
        idx   = desc_idx_t'(i);
      end
    end
  end
endmodule

// File: rtl/dma_fsm.sv
// Descriptor sequencer: walks the table, launches read/write streamers per
// eligible descriptor and reports done/abort/error status to the CSRs.
module dma_fsm
  import dma_utils_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               dma_go_i,
  input  logic                               dma_abort_i,
  input  s_dma_desc_t [`DMA_NUM_DESC-1:0]    dma_desc_i,
  input  logic                               dma_axi_err_i,
  output s_dma_str_in_t                      dma_stream_rd_o,
  output s_dma_str_in_t                      dma_stream_wr_o,
  input  s_dma_str_out_t                     dma_stream_rd_i,
  input  s_dma_str_out_t                     dma_stream_wr_i,
  output s_dma_status_t                      dma_status_o,
  output logic                               dma_done_o
);
  dma_fsm_st_t         state_ff;
  desc_idx_t           cur_idx_ff;
  logic                rd_seen_ff;
  logic                wr_seen_ff;
  logic                issue_ff;
  logic                done_ff;
  s_dma_status_t       status_ff;

  logic [NUM_DESC-1:0] eligible;
  logic                first_found;
  logic                next_found;
  desc_idx_t           first_idx;
  desc_idx_t           next_idx;
  desc_start_t         next_start;
  logic                rd_seen;
  logic                wr_seen;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_DESC; i++) begin
      eligible[i] = desc_eligible(dma_desc_i[i]);
    end
  end

  assign next_start = desc_start_t'(cur_idx_ff) + desc_start_t'(1);

  dma_desc_sel u_sel_first (
    .eligible (eligible),
    .start    ('0),
    .found    (first_found),
    .idx      (first_idx)
  );

  dma_desc_sel u_sel_next (
    .eligible (eligible),
    .start    (next_start),
    .found    (next_found),
    .idx      (next_idx)
  );

  // A done pulse in the current cycle counts immediately so none is lost.
  assign rd_seen = rd_seen_ff | dma_stream_rd_i.done;
  assign wr_seen = wr_seen_ff | dma_stream_wr_i.done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_ff   <= IDLE;
      cur_idx_ff <= '0;
      rd_seen_ff <= 1'b0;
      wr_seen_ff <= 1'b0;
      issue_ff   <= 1'b0;
      done_ff    <= 1'b0;
      status_ff  <= '0;
    end else begin
      issue_ff <= 1'b0;
      done_ff  <= 1'b0;

      if ((state_ff inside {ISSUE, WAIT, ABORT}) && dma_axi_err_i && !status_ff.error) begin
        status_ff.error   <= 1'b1;
        status_ff.err_idx <= cur_idx_ff;
      end

      case (state_ff)
        IDLE: begin
          if (dma_go_i) begin
            status_ff <= '0;
            if (first_found) begin
              cur_idx_ff     <= first_idx;
              status_ff.busy <= 1'b1;
              issue_ff       <= 1'b1;
              state_ff       <= ISSUE;
            end else begin
              state_ff <= DONE;
            end
          end
        end
        ISSUE: begin
          rd_seen_ff <= 1'b0;
          wr_seen_ff <= 1'b0;
          if (dma_abort_i) begin
            status_ff.aborted <= 1'b1;
            state_ff          <= ABORT;
          end else begin
            state_ff <= WAIT;
          end
        end
        WAIT: begin
          rd_seen_ff <= rd_seen;
          wr_seen_ff <= wr_seen;
          if (dma_abort_i) begin
            status_ff.aborted <= 1'b1;
            state_ff          <= ABORT;
          end else if (rd_seen && wr_seen) begin
            state_ff <= NEXT;
          end
        end
        NEXT: begin
          if (dma_abort_i) begin
            status_ff.aborted <= 1'b1;
            state_ff          <= DONE;
          end else if (status_ff.error) begin
            state_ff <= DONE;
          end else if (next_found) begin
            cur_idx_ff <= next_idx;
            issue_ff   <= 1'b1;
            state_ff   <= ISSUE;
          end else begin
            state_ff <= DONE;
          end
        end
        ABORT: begin
          // Streamers may still be draining a beat; wait for both to finish.
          rd_seen_ff <= rd_seen;
          wr_seen_ff <= wr_seen;
          if (rd_seen && wr_seen) begin
            state_ff <= DONE;
          end
        end
        DONE: begin
          done_ff        <= 1'b1;
          status_ff.done <= 1'b1;
          status_ff.busy <= 1'b0;
          state_ff       <= IDLE;
        end
        default: state_ff <= IDLE;
      endcase
    end
  end

  assign dma_stream_rd_o.valid = issue_ff;
  assign dma_stream_rd_o.idx   = cur_idx_ff;
  assign dma_stream_wr_o.valid = issue_ff;
  assign dma_stream_wr_o.idx   = cur_idx_ff;
  assign dma_status_o          = status_ff;
  assign dma_done_o            = done_ff;
endmodule

// File: tb/tb_dma_fsm.sv
// Bench for dma_fsm: scenario tasks drive the CSR/streamer side; a launch
// monitor pops expected descriptor indices from a scoreboard queue.
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 4
`endif

module tb_dma_fsm;
  import dma_utils_pkg::*;

  logic                            clk;
  logic                            rst;
  logic                            go;
  logic                            abort;
  logic                            axi_err;
  s_dma_desc_t [`DMA_NUM_DESC-1:0] desc;
  s_dma_str_in_t                   rd_o;
  s_dma_str_in_t                   wr_o;
  s_dma_str_out_t                  rd_in;
  s_dma_str_out_t                  wr_in;
  s_dma_status_t                   status;
  logic                            done_o;

  int        checks = 0;
  int        errors = 0;
  desc_idx_t exp_q[$];
  desc_idx_t mon_exp;

  dma_fsm dut (
    .clk             (clk),
    .rst             (rst),
    .dma_go_i        (go),
    .dma_abort_i     (abort),
    .dma_desc_i      (desc),
    .dma_axi_err_i   (axi_err),
    .dma_stream_rd_o (rd_o),
    .dma_stream_wr_o (wr_o),
    .dma_stream_rd_i (rd_in),
    .dma_stream_wr_i (wr_in),
    .dma_status_o    (status),
    .dma_done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch monitor: every valid must match the next expected index on both ports.
  always @(negedge clk) begin
    if (rd_o.valid || wr_o.valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected: rd_valid=%0b wr_valid=%0b idx=%0d, no launch expected",
                 rd_o.valid, wr_o.valid, rd_o.idx);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_o.valid !== 1'b1 || wr_o.valid !== 1'b1 || rd_o.idx !== mon_exp || wr_o.idx !== mon_exp) begin
          errors++;
          $display("FAIL launch_idx: rd=%0b/%0d wr=%0b/%0d, expected both valid idx %0d",
                   rd_o.valid, rd_o.idx, wr_o.valid, wr_o.idx, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [`DMA_NUM_DESC-1:0] en, input logic [`DMA_NUM_DESC-1:0] nz);
    for (int i = 0; i < `DMA_NUM_DESC; i++) begin
      desc[i].enable    = en[i];
      desc[i].num_bytes = nz[i] ? 16'(64 * (i + 1)) : 16'd0;
      desc[i].src_addr  = $urandom;
      desc[i].dst_addr  = $urandom;
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Called in the ISSUE cycle; returns in the cycle after the last done (NEXT).
  task automatic pulse_dones(input int rd_dly, input int wr_dly);
    int n;
    n = (rd_dly > wr_dly) ? rd_dly : wr_dly;
    for (int c = 1; c <= n; c++) begin
      tick();
      rd_in.done = (c == rd_dly);
      wr_in.done = (c == wr_dly);
    end
    tick();
    rd_in.done = 1'b0;
    wr_in.done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({rd_o, wr_o, done_o} !== '0) begin
      errors++;
      $display("FAIL reset_streams: rd=%h wr=%h done=%b, expected all 0", rd_o, wr_o, done_o);
    end
    checks++;
    if (status !== '0) begin
      errors++;
      $display("FAIL reset_status: got %h expected 0", status);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_two_desc();
    set_desc(4'b1101, 4'b0111);
    exp_q.push_back(desc_idx_t'(0));
    exp_q.push_back(desc_idx_t'(2));
    pulse_go();
    checks++;
    if (rd_o.valid !== 1'b1 || status.busy !== 1'b1) begin
      errors++;
      $display("FAIL two_launch0: valid=%b busy=%b expected 1/1", rd_o.valid, status.busy);
    end
    pulse_dones(2, 3);
    tick();
    checks++;
    if (rd_o.valid !== 1'b1) begin
      errors++;
      $display("FAIL two_launch2: valid=%b expected 1", rd_o.valid);
    end
    pulse_dones(1, 1);
    tick();
    checks++;
    if (done_o !== 1'b0 || status.busy !== 1'b1) begin
      errors++;
      $display("FAIL two_done_cycle: done_o=%b busy=%b expected 0/1", done_o, status.busy);
    end
    tick();
    checks++;
    if (done_o !== 1'b1 || {status.busy, status.done, status.error, status.aborted} !== 4'b0100) begin
      errors++;
      $display("FAIL two_complete: done_o=%b bdea=%b%b%b%b expected 1 / 0100",
               done_o, status.busy, status.done, status.error, status.aborted);
    end
    tick();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL two_done_pulse_width: done_o=%b expected 0", done_o);
    end
  endtask

  task automatic test_done_order();
    set_desc(4'b0111, 4'b1111);
    exp_q.push_back(desc_idx_t'(0));
    exp_q.push_back(desc_idx_t'(1));
    exp_q.push_back(desc_idx_t'(2));
    pulse_go();
    pulse_dones(1, 6);
    checks++;
    if (rd_o.valid !== 1'b0) begin
      errors++;
      $display("FAIL order_early_launch: valid=%b expected 0 at last done+1", rd_o.valid);
    end
    tick();
    checks++;
    if (rd_o.valid !== 1'b1 || rd_o.idx !== desc_idx_t'(1)) begin
      errors++;
      $display("FAIL order_rd_first: valid=%b idx=%0d expected 1/1", rd_o.valid, rd_o.idx);
    end
    pulse_dones(3, 3);
    tick();
    checks++;
    if (rd_o.valid !== 1'b1 || rd_o.idx !== desc_idx_t'(2)) begin
      errors++;
      $display("FAIL order_same_cycle: valid=%b idx=%0d expected 1/2", rd_o.valid, rd_o.idx);
    end
    pulse_dones(1, 1);
    tick();
    tick();
    checks++;
    if (done_o !== 1'b1 || status.done !== 1'b1) begin
      errors++;
      $display("FAIL order_complete: done_o=%b status_done=%b expected 1/1", done_o, status.done);
    end
    tick();
  endtask

  task automatic test_nothing_eligible();
    set_desc(4'b1111, 4'b0000);
    pulse_go();
    checks++;
    if (done_o !== 1'b0 || status.busy !== 1'b0) begin
      errors++;
      $display("FAIL none_n1: done_o=%b busy=%b expected 0/0", done_o, status.busy);
    end
    tick();
    checks++;
    if (done_o !== 1'b1 || status.done !== 1'b1) begin
      errors++;
      $display("FAIL none_n2: done_o=%b status_done=%b expected 1/1", done_o, status.done);
    end
    tick();
  endtask

  task automatic test_abort();
    logic saw_done;
    set_desc(4'b0111, 4'b1111);
    exp_q.push_back(desc_idx_t'(0));
    pulse_go();
    tick();
    abort      = 1'b1;
    rd_in.done = 1'b1;
    tick();
    abort      = 1'b0;
    rd_in.done = 1'b0;
    checks++;
    if (status.aborted !== 1'b1 || status.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_flag: aborted=%b busy=%b expected 1/1", status.aborted, status.busy);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_early_done: done_o pulsed before write done, expected none");
    end
    wr_in.done = 1'b1;
    tick();
    wr_in.done = 1'b0;
    tick();
    checks++;
    if (done_o !== 1'b1 || {status.busy, status.done, status.aborted} !== 3'b011) begin
      errors++;
      $display("FAIL abort_complete: done_o=%b bda=%b%b%b expected 1 / 011",
               done_o, status.busy, status.done, status.aborted);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_error();
    set_desc(4'b0111, 4'b1111);
    exp_q.push_back(desc_idx_t'(0));
    exp_q.push_back(desc_idx_t'(1));
    pulse_go();
    pulse_dones(1, 2);
    tick();
    tick();
    axi_err = 1'b1;
    tick();
    axi_err = 1'b0;
    checks++;
    if (status.error !== 1'b1 || status.err_idx !== desc_idx_t'(1)) begin
      errors++;
      $display("FAIL err_first: error=%b err_idx=%0d expected 1/1", status.error, status.err_idx);
    end
    axi_err = 1'b1;
    tick();
    axi_err = 1'b0;
    checks++;
    if (status.err_idx !== desc_idx_t'(1)) begin
      errors++;
      $display("FAIL err_second: err_idx=%0d expected 1", status.err_idx);
    end
    rd_in.done = 1'b1;
    wr_in.done = 1'b1;
    tick();
    rd_in.done = 1'b0;
    wr_in.done = 1'b0;
    tick();
    tick();
    checks++;
    if (done_o !== 1'b1 || {status.done, status.error, status.aborted} !== 3'b110 ||
        status.err_idx !== desc_idx_t'(1)) begin
      errors++;
      $display("FAIL err_complete: done_o=%b dea=%b%b%b err_idx=%0d expected 1 / 110 / 1",
               done_o, status.done, status.error, status.aborted, status.err_idx);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_go_busy_reset();
    set_desc(4'b0011, 4'b1111);
    exp_q.push_back(desc_idx_t'(0));
    pulse_go();
    checks++;
    if ({status.busy, status.done, status.error, status.aborted} !== 4'b1000) begin
      errors++;
      $display("FAIL sticky_clear: bdea=%b%b%b%b expected 1000",
               status.busy, status.done, status.error, status.aborted);
    end
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    checks++;
    if (rd_o.valid !== 1'b0 || status.busy !== 1'b1) begin
      errors++;
      $display("FAIL go_busy: valid=%b busy=%b expected 0/1", rd_o.valid, status.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({rd_o, wr_o, done_o} !== '0 || status !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: rd=%h wr=%h done=%b status=%h expected all 0", rd_o, wr_o, done_o, status);
    end
    tick();
    tick();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done_o=%b expected 0", done_o);
    end
    exp_q.push_back(desc_idx_t'(0));
    exp_q.push_back(desc_idx_t'(1));
    pulse_go();
    pulse_dones(1, 1);
    tick();
    pulse_dones(2, 1);
    tick();
    tick();
    checks++;
    if (done_o !== 1'b1 || {status.busy, status.done} !== 2'b01) begin
      errors++;
      $display("FAIL fresh_run: done_o=%b bd=%b%b expected 1 / 01", done_o, status.busy, status.done);
    end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    go         = 1'b0;
    abort      = 1'b0;
    axi_err    = 1'b0;
    rd_in.done = 1'b0;
    wr_in.done = 1'b0;
    desc       = '0;
    test_reset();
    test_two_desc();
    test_done_order();
    test_nothing_eligible();
    test_abort();
    test_error();
    test_go_busy_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL launches_missing: %0d expected launches never seen, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
